adc_sum_integ_ctrl: RTL and testbench
=====================================

ADC_SUM_INTEG_CTRL -- requirements
Module: adc_sum_integ_ctrl

Interface
REQ-001 SHALL have parameter C_LEN_W, default 16, width of integ_len and sample_cnt.
REQ-002 SHALL have port OPB_Clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port OPB_Rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, one-cycle pulse that begins an integration.
REQ-005 SHALL have port continuous, input, 1, re-arm automatically after each result.
REQ-006 SHALL have port integ_len, input, C_LEN_W, samples per integration; 0 means 2^C_LEN_W.
REQ-007 SHALL have port smp_valid, input, 1, sample strobe.
REQ-008 SHALL have port smp_data, input, 8, signed ADC sample.
REQ-009 SHALL have port sum_data, output, 32, latched power sum, driving the software-readable register.
REQ-010 SHALL have port sum_ready, output, 1, sum_data holds an unread result.
REQ-011 SHALL have port sum_ack, input, 1, reader consumed the result.
REQ-012 SHALL have port busy, output, 1, integration in progress.
REQ-013 SHALL have port overrun, output, 1, sticky: an unread result was overwritten.
REQ-014 SHALL have port sample_cnt, output, C_LEN_W, samples accumulated in the current integration.
REQ-015 SHALL have port peak_abs, output, 8, largest |smp_data| of the last latched integration.

Function
REQ-016 SHALL implement states IDLE, INTEG and DRAIN.
REQ-017 IDLE->INTEG on start; integ_len SHALL be captured at that edge, and sample_cnt and accumulator SHALL clear.
REQ-018 start in INTEG or DRAIN SHALL be ignored.
REQ-019 In INTEG each smp_valid SHALL accept one sample and increment sample_cnt; the square smp_data*smp_data is registered 1 cycle, then added to a 32-bit accumulator; the sum cannot overflow at C_LEN_W<=16.
REQ-020 The sample accepted at edge E that completes the count SHALL be tagged last.
REQ-021 sum_data SHALL update and sum_ready SHALL rise at edge E+2.
REQ-022 At the last sample with continuous=0, the block SHALL go INTEG->DRAIN, then DRAIN->IDLE at E+2.
REQ-023 At the last sample with continuous=1, the block SHALL stay in INTEG, start a fresh count at E+1 and re-capture integ_len; no sample is lost, because the last tag restarts the accumulator from the next product.
REQ-024 Deasserting continuous mid-integration SHALL finish the current integration, then go to IDLE.
REQ-025 sum_ack SHALL clear sum_ready at the next edge; if sum_ack coincides with a new latch, the new result wins, sum_ready stays 1 and overrun is not set.
REQ-026 A latch while sum_ready=1 without ack SHALL overwrite sum_data and set overrun; overrun SHALL clear only on an accepted start.
REQ-027 busy SHALL be 1 in INTEG and DRAIN.
REQ-028 smp_valid in IDLE SHALL be ignored.
REQ-029 -128 squared SHALL equal 16384, with the multiply signed.

Reset
REQ-030 OPB_Rst SHALL asynchronously force IDLE, with sum_data=0, sum_ready=0, busy=0, overrun=0, sample_cnt=0, peak_abs=0, and SHALL clear the pipeline and last tag.
REQ-031 Reset mid-integration SHALL discard partial results; no sum_ready SHALL follow its release.

Configuration
REQ-032 Macro ADC_SUM_PEAK_EN defined: a running max of |smp_data| (|-128| = 128) SHALL latch to peak_abs together with sum_data, and SHALL clear at each integration start.
REQ-033 Macro ADC_SUM_PEAK_EN undefined: peak_abs SHALL be tied to 0, no peak logic SHALL be present, and all other behaviour SHALL be identical.

Verification
REQ-034 integ_len=4, samples 1,2,3,4 on consecutive cycles, continuous=0 -> sum_data=30 and sum_ready at 2 edges after the 4th sample; state IDLE; busy=0.
REQ-035 integ_len=2, continuous=1, back-to-back samples -128,-128,5,5 -> first result 32768, second 50, with no gap and no dropped sample.
REQ-036 Result pending, no ack, next integration completes -> sum_data=new value and overrun=1; next start -> overrun=0.
REQ-037 sum_ack on the same edge as a new latch -> sum_ready stays 1, overrun=0.
REQ-038 OPB_Rst asserted after 3 of 8 samples -> all outputs 0 immediately; no sum_ready after release until a new start.
REQ-039 ADC_SUM_PEAK_EN, samples 7,-100,50 -> peak_abs=100; without the macro -> peak_abs=0.

Source files
------------

// File: rtl/adc_sum_integ_ctrl.sv
// ADC power integrator: sums smp_data^2 over integ_len samples, latches
// the result to sum_data with ready/ack, overrun and optional peak tracking.
// Ports: OPB_Clk/OPB_Rst (async high), start/continuous/integ_len control,
//   smp_valid/smp_data samples, sum_data/sum_ready/sum_ack result handshake,
//   busy, overrun (sticky), sample_cnt, peak_abs.
// Macro ADC_SUM_PEAK_EN enables the |sample| peak tracker; else peak_abs=0.
module adc_sum_integ_ctrl #(
  parameter int C_LEN_W = 16
) (
  input  logic               OPB_Clk,
  input  logic               OPB_Rst,
  input  logic               start,
  input  logic               continuous,
  input  logic [C_LEN_W-1:0] integ_len,
  input  logic               smp_valid,
  input  logic [7:0]         smp_data,
  output logic [31:0]        sum_data,
  output logic               sum_ready,
  input  logic               sum_ack,
  output logic               busy,
  output logic               overrun,
  output logic [C_LEN_W-1:0] sample_cnt,
  output logic [7:0]         peak_abs
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INTEG = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [C_LEN_W-1:0] len_q, len_d;
  logic [C_LEN_W-1:0] cnt_q, cnt_d;
  logic [C_LEN_W-1:0] cnt_inc;
  logic [15:0]        sq_q, sq_d;
  logic               sq_last_q, sq_last_d;
  logic               fin_q, fin_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        acc_base;
  logic [31:0]        sum_q, sum_d;
  logic               rdy_q, rdy_d;
  logic               ovr_q, ovr_d;

  logic               start_acc;
  logic               take;
  logic               last;
  logic signed [15:0] prod;

  assign start_acc = (state_q == S_IDLE) && start;
  assign take      = (state_q == S_INTEG) && smp_valid;
  assign cnt_inc   = cnt_q + 1'b1;
  // A length of 0 wraps: the count completes when cnt_inc rolls to 0.
  assign last      = take && (cnt_inc == len_q);
  assign prod      = $signed(smp_data) * $signed(smp_data);

  // State register
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_INTEG;
      S_INTEG: if (last && !continuous) state_d = S_DRAIN;
      S_DRAIN: if (fin_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_INTEG) || (state_q == S_DRAIN);
  end

  // Datapath: square stage, accumulate stage, latch stage.
  // fin_q marks the cycle where acc_q holds a completed sum; the same
  // flag restarts the accumulator so the next product begins a new sum.
  always_comb begin
    len_d     = len_q;
    cnt_d     = cnt_q;
    sq_d      = take ? prod : 16'd0;
    sq_last_d = last;
    fin_d     = sq_last_q;
    acc_base  = fin_q ? 32'd0 : acc_q;
    acc_d     = acc_base + {16'd0, sq_q};
    sum_d     = sum_q;
    rdy_d     = rdy_q & ~sum_ack;
    ovr_d     = ovr_q;
    if (start_acc) begin
      len_d = integ_len;
      cnt_d = '0;
      acc_d = 32'd0;
      ovr_d = 1'b0;
    end
    if (take) begin
      if (last && continuous) begin
        cnt_d = '0;
        len_d = integ_len;
      end else begin
        cnt_d = cnt_inc;
      end
    end
    if (fin_q) begin
      sum_d = acc_q;
      rdy_d = 1'b1;
      if (rdy_q && !sum_ack) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      len_q     <= '0;
      cnt_q     <= '0;
      sq_q      <= '0;
      sq_last_q <= 1'b0;
      fin_q     <= 1'b0;
      acc_q     <= '0;
      sum_q     <= '0;
      rdy_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      sq_q      <= sq_d;
      sq_last_q <= sq_last_d;
      fin_q     <= fin_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      rdy_q     <= rdy_d;
      ovr_q     <= ovr_d;
    end
  end

  assign sum_data   = sum_q;
  assign sum_ready  = rdy_q;
  assign overrun    = ovr_q;
  assign sample_cnt = cnt_q;

`ifdef ADC_SUM_PEAK_EN
  // Peak runs in step with the square pipeline so it restarts and
  // latches on exactly the same edges as the sum.
  logic [7:0] abs_q, abs_d;
  logic [7:0] pk_q, pk_d;
  logic [7:0] pk_base;
  logic [7:0] peak_q, peak_d;

  always_comb begin
    abs_d   = 8'd0;
    if (take) abs_d = smp_data[7] ? (~smp_data + 8'd1) : smp_data;
    pk_base = fin_q ? 8'd0 : pk_q;
    pk_d    = (abs_q > pk_base) ? abs_q : pk_base;
    if (start_acc) pk_d = 8'd0;
    peak_d  = fin_q ? pk_q : peak_q;
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      abs_q  <= '0;
      pk_q   <= '0;
      peak_q <= '0;
    end else begin
      abs_q  <= abs_d;
      pk_q   <= pk_d;
      peak_q <= peak_d;
    end
  end

  assign peak_abs = peak_q;
`else
  assign peak_abs = 8'd0;
`endif

endmodule

// File: tb/tb_adc_sum_integ_ctrl.sv
// Testbench for adc_sum_integ_ctrl: transaction-level model checked each
// cycle plus directed vectors with hand-computed expectations.
module tb_adc_sum_integ_ctrl;

`ifdef ADC_SUM_PEAK_EN
  localparam bit PK_EN = 1'b1;
`else
  localparam bit PK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] integ_len = '0;
  logic        smp_valid = 1'b0;
  logic [7:0]  smp_data = '0;
  logic        sum_ack = 1'b0;
  logic [31:0] sum_data;
  logic        sum_ready;
  logic        busy;
  logic        overrun;
  logic [15:0] sample_cnt;
  logic [7:0]  peak_abs;

  adc_sum_integ_ctrl #(.C_LEN_W(16)) dut (
    .OPB_Clk    (clk),
    .OPB_Rst    (rst),
    .start      (start),
    .continuous (continuous),
    .integ_len  (integ_len),
    .smp_valid  (smp_valid),
    .smp_data   (smp_data),
    .sum_data   (sum_data),
    .sum_ready  (sum_ready),
    .sum_ack    (sum_ack),
    .busy       (busy),
    .overrun    (overrun),
    .sample_cnt (sample_cnt),
    .peak_abs   (peak_abs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- transaction model ----------------
  typedef struct {
    longint cyc;
    longint sum;
    int     pk;
  } ev_t;

  ev_t    ev_q[$];
  int     m_state = 0;  // 0 idle, 1 integrating, 2 draining
  int     m_len = 0;
  int     m_cnt = 0;
  longint m_acc = 0;
  int     m_pk = 0;
  longint m_drain_end = 0;
  longint m_cyc = 0;
  longint m_sum = 0;
  bit     m_rdy = 0;
  bit     m_ovr = 0;
  int     m_peak = 0;

  always @(posedge clk) begin
    int st0;
    bit latched;
    ev_t e;
    m_cyc++;
    if (rst) begin
      ev_q.delete();
      m_state = 0; m_cnt = 0; m_acc = 0; m_pk = 0;
      m_sum = 0; m_rdy = 0; m_ovr = 0; m_peak = 0;
    end else begin
      st0 = m_state;
      latched = 0;
      if (ev_q.size() > 0 && ev_q[0].cyc == m_cyc) begin
        e = ev_q.pop_front();
        if (m_rdy && !sum_ack) m_ovr = 1;
        m_sum = e.sum;
        m_peak = e.pk;
        m_rdy = 1;
        latched = 1;
      end
      if (!latched && sum_ack) m_rdy = 0;
      if (st0 == 2 && m_cyc == m_drain_end) m_state = 0;
      if (st0 == 0 && start) begin
        m_state = 1;
        m_len = (integ_len == 0) ? 65536 : int'(integ_len);
        m_cnt = 0; m_acc = 0; m_pk = 0; m_ovr = 0;
      end else if (st0 == 1 && smp_valid) begin
        int x, a;
        x = int'($signed(smp_data));
        a = (x < 0) ? -x : x;
        m_acc += longint'(x * x);
        if (a > m_pk) m_pk = a;
        m_cnt++;
        if (m_cnt == m_len) begin
          e.cyc = m_cyc + 2;
          e.sum = m_acc;
          e.pk  = m_pk;
          ev_q.push_back(e);
          if (continuous) begin
            m_cnt = 0; m_acc = 0; m_pk = 0;
            m_len = (integ_len == 0) ? 65536 : int'(integ_len);
          end else begin
            m_state = 2;
            m_drain_end = m_cyc + 2;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #2;
    chk("busy", busy, (m_state != 0) ? 1 : 0);
    chk("sum_ready", sum_ready, m_rdy);
    chk("sum_data", sum_data, m_sum);
    chk("overrun", overrun, m_ovr);
    chk("sample_cnt", sample_cnt, m_cnt % 65536);
    chk("peak_abs", peak_abs, PK_EN ? m_peak : 0);
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input int len, input bit cont);
    @(negedge clk);
    start = 1'b1;
    integ_len = 16'(len);
    continuous = cont;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic smp(input int x);
    smp_valid = 1'b1;
    smp_data = 8'(x);
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sum_data", sum_data, 0);
    chk("rst_sum_ready", sum_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Samples in IDLE are ignored
    smp(9);
    smp(9);
    chk("idle_cnt", sample_cnt, 0);

    // Basic: 1,2,3,4 -> 30; a start pulse mid-integration is ignored
    do_start(4, 0);
    smp(1);
    start = 1'b1;
    smp(2);
    start = 1'b0;
    smp(3);
    smp(4);
    chk("b_not_ready_e1", sum_ready, 0);
    @(negedge clk);
    chk("b_not_ready_e2", sum_ready, 0);
    @(negedge clk);
    chk("b_sum", sum_data, 30);
    chk("b_ready", sum_ready, 1);
    chk("b_busy", busy, 0);
    sum_ack = 1'b1;
    @(negedge clk);
    sum_ack = 1'b0;

    // Continuous, back-to-back: -128,-128 | 5,5; continuous dropped mid-way
    do_start(2, 1);
    smp_valid = 1'b1;
    smp_data = 8'h80;
    @(negedge clk);
    @(negedge clk);
    smp_data = 8'd5;
    @(negedge clk);
    continuous = 1'b0;
    @(negedge clk);
    smp_valid = 1'b0;
    chk("c_sum1", sum_data, 32768);
    chk("c_peak1", peak_abs, PK_EN ? 128 : 0);
    chk("c_ovr1", overrun, 0);
    sum_ack = 1'b1;
    @(negedge clk);
    sum_ack = 1'b0;
    chk("c_acked", sum_ready, 0);
    @(negedge clk);
    chk("c_sum2", sum_data, 50);
    chk("c_ready2", sum_ready, 1);
    chk("c_busy", busy, 0);

    // Overrun: unread 50, new result 9
    do_start(1, 0);
    smp(3);
    @(negedge clk);
    @(negedge clk);
    chk("o_sum", sum_data, 9);
    chk("o_ovr", overrun, 1);
    do_start(1, 0);
    chk("o_ovr_clr", overrun, 0);

    // Ack coinciding with a new latch
    smp(2);
    @(negedge clk);
    sum_ack = 1'b1;
    @(negedge clk);
    sum_ack = 1'b0;
    chk("a_sum", sum_data, 4);
    chk("a_ready", sum_ready, 1);
    chk("a_ovr", overrun, 0);

    // Reset mid-integration
    do_start(8, 0);
    smp(10);
    smp(10);
    smp(10);
    chk("r_cnt3", sample_cnt, 3);
    rst = 1'b1;
    #1;
    chk("r_sum", sum_data, 0);
    chk("r_ready", sum_ready, 0);
    chk("r_busy", busy, 0);
    chk("r_ovr", overrun, 0);
    chk("r_cnt", sample_cnt, 0);
    chk("r_peak", peak_abs, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("r_after_ready", sum_ready, 0);
    chk("r_after_busy", busy, 0);

    // Peak: 7,-100,50 -> 49+10000+2500
    do_start(3, 0);
    smp(7);
    smp(-100);
    smp(50);
    @(negedge clk);
    @(negedge clk);
    chk("p_sum", sum_data, 12549);
    chk("p_peak", peak_abs, PK_EN ? 100 : 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
